// File: rtl/mcl_fxd_pkg.sv
// Shared fixed-point definitions for the Horner polynomial pipeline.
// Word format, saturating multiply helper and fork port indices.
package mcl_fxd_pkg;

    localparam int FXD_Q   = 4;
    localparam int FXD_N   = 8;
    localparam int FXD_MAX = (1 << (FXD_N - 1)) - 1;

    // Bit positions inside the pending mask {mult_1,mult_2,add_1,pl_x,pl_x2}.
    typedef enum logic [2:0] {
        P_PL_X2  = 3'd0,
        P_PL_X   = 3'd1,
        P_ADD_1  = 3'd2,
        P_MULT_2 = 3'd3,
        P_MULT_1 = 3'd4
    } fork_port_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } feed_state_e;

    // Signed product, arithmetic shift by q (floor), clamp to n-bit range.
    // Operands arrive sign-extended to 32 bits; caller keeps the low n bits.
    function automatic logic signed [31:0] fxd_mul_sat(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 q,
        input int                 n
    );
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        logic signed [63:0] p;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        pa = 64'(a);
        pb = 64'(b);
        p  = (pa * pb) >>> q;
        mx = (64'sd1 <<< (n - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (n - 1));
        if (p > mx) begin
            p = mx;
        end else if (p < mn) begin
            p = mn;
        end
        return p[31:0];
    endfunction

endpackage

// File: rtl/mcl_fxd_square.sv
// Combinational saturating fixed-point squarer.
// Shared by the Horner feed and later range-reduction stages.
module mcl_fxd_square
    import mcl_fxd_pkg::*;
#(
    parameter int Q = FXD_Q,
    parameter int N = FXD_N
) (
    input  logic [N-1:0] x_i,
    output logic [N-1:0] sq_o
);

    // Square through the common multiplier rule so rounding matches the pipe.
    always_comb begin
        sq_o = N'(fxd_mul_sat(32'(signed'(x_i)), 32'(signed'(x_i)), Q, N));
    end

endmodule

// File: rtl/mcl_fxd_horner_feed.sv
// Horner pipeline front end: registers x and x^2 once, then forks
// five streams that each downstream port consumes independently.
module mcl_fxd_horner_feed
    import mcl_fxd_pkg::*;
#(
    parameter int               FXD_Q  = 4,
    parameter int               FXD_N  = 8,
    parameter logic [FXD_N-1:0] COEF_A = '0,
    parameter logic [FXD_N-1:0] COEF_B = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_avail_x,
    output logic             pre_get_x,
    input  logic [FXD_N-1:0] pre_data_x,
    output logic             post_avail_mult_1,
    input  logic             post_get_mult_1,
    output logic [FXD_N-1:0] post_data_mult_1,
    output logic             post_avail_mult_2,
    input  logic             post_get_mult_2,
    output logic [FXD_N-1:0] post_data_mult_2,
    output logic             post_avail_add_1,
    input  logic             post_get_add_1,
    output logic [FXD_N-1:0] post_data_add_1,
    output logic             post_avail_pl_x,
    input  logic             post_get_pl_x,
    output logic [FXD_N-1:0] post_data_pl_x,
    output logic             post_avail_pl_x2,
    input  logic             post_get_pl_x2,
    output logic [FXD_N-1:0] post_data_pl_x2
);

    feed_state_e      state_q;
    logic [4:0]       pend_q;
    logic [4:0]       pend_d;
    logic [FXD_N-1:0] x_q;
    logic [FXD_N-1:0] x_d;
    logic [FXD_N-1:0] x2_q;
    logic [FXD_N-1:0] x2_d;
    logic [FXD_N-1:0] sq;
    logic [4:0]       get;
    logic [4:0]       drain;
    logic [4:0]       avail;
    logic             load;

    mcl_fxd_square #(
        .Q (FXD_Q),
        .N (FXD_N)
    ) u_square (
        .x_i  (pre_data_x),
        .sq_o (sq)
    );

    // Gather per-port consumes and decide whether a new x may enter.
    always_comb begin
        get[P_MULT_1] = post_get_mult_1;
        get[P_MULT_2] = post_get_mult_2;
        get[P_ADD_1]  = post_get_add_1;
        get[P_PL_X]   = post_get_pl_x;
        get[P_PL_X2]  = post_get_pl_x2;
        drain         = ~pend_q | get;
        pre_get_x     = &drain;
        load          = pre_avail_x & pre_get_x;
    end

    // Next state: consumed ports clear, a load refills every port.
    always_comb begin
        pend_d = pend_q & ~get;
        x_d    = x_q;
        x2_d   = x2_q;
        if (load) begin
            pend_d = '1;
            x_d    = pre_data_x;
            x2_d   = sq;
        end
    end

    // Fork register and EMPTY/HOLD state; reset drops partial transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            pend_q  <= '0;
            x_q     <= '0;
            x2_q    <= '0;
        end else begin
            state_q <= (pend_d == '0) ? ST_EMPTY : ST_HOLD;
            pend_q  <= pend_d;
            x_q     <= x_d;
            x2_q    <= x2_d;
        end
    end

    // Outputs come straight from registers; no path from pre_data_x.
    always_comb begin
        avail             = (state_q == ST_HOLD) ? pend_q : '0;
        post_avail_mult_1 = avail[P_MULT_1];
        post_avail_mult_2 = avail[P_MULT_2];
        post_avail_add_1  = avail[P_ADD_1];
        post_avail_pl_x   = avail[P_PL_X];
        post_avail_pl_x2  = avail[P_PL_X2];
        post_data_mult_1  = COEF_A;
        post_data_add_1   = COEF_B;
        post_data_pl_x    = x_q;
        post_data_mult_2  = x2_q;
        post_data_pl_x2   = x2_q;
    end

endmodule

// File: tb/tb_mcl_fxd_horner_feed.sv
// Self-checking bench for mcl_fxd_horner_feed (Q=4, N=8).
// Directed scenarios followed by random traffic against a port model.
module tb_mcl_fxd_horner_feed;

    localparam logic [7:0] CA = 8'h5A;
    localparam logic [7:0] CB = 8'hC3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_avail_x;
    logic       pre_get_x;
    logic [7:0] pre_data_x;
    logic       av_m1, av_m2, av_a1, av_px, av_px2;
    logic       g_m1, g_m2, g_a1, g_px, g_px2;
    logic [7:0] d_m1, d_m2, d_a1, d_px, d_px2;
    logic [4:0] avails;

    int checks = 0;
    int errors = 0;

    // Reference: which ports still owe data, and the words they carry.
    bit   [4:0] pm;
    logic [7:0] xm;
    logic [7:0] x2m;

    always #5 clk = ~clk;

    assign avails = {av_m1, av_m2, av_a1, av_px, av_px2};

    mcl_fxd_horner_feed #(
        .FXD_Q  (4),
        .FXD_N  (8),
        .COEF_A (CA),
        .COEF_B (CB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pre_avail_x       (pre_avail_x),
        .pre_get_x         (pre_get_x),
        .pre_data_x        (pre_data_x),
        .post_avail_mult_1 (av_m1),
        .post_get_mult_1   (g_m1),
        .post_data_mult_1  (d_m1),
        .post_avail_mult_2 (av_m2),
        .post_get_mult_2   (g_m2),
        .post_data_mult_2  (d_m2),
        .post_avail_add_1  (av_a1),
        .post_get_add_1    (g_a1),
        .post_data_add_1   (d_a1),
        .post_avail_pl_x   (av_px),
        .post_get_pl_x     (g_px),
        .post_data_pl_x    (d_px),
        .post_avail_pl_x2  (av_px2),
        .post_get_pl_x2    (g_px2),
        .post_data_pl_x2   (d_px2)
    );

    // Real-number square: floor(x*x/16), clamped to the largest positive word.
    function automatic logic [7:0] ref_sq(input logic [7:0] x);
        int v;
        int p;
        v = int'($signed(x));
        p = (v * v) / 16;
        if (p > 127) p = 127;
        return p[7:0];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare outputs, then advance the model.
    task automatic cyc(input logic rst, input logic av, input logic [7:0] x,
                       input logic [4:0] g);
        bit rdy;
        @(negedge clk);
        rst_n       = rst;
        pre_avail_x = av;
        pre_data_x  = x;
        {g_m1, g_m2, g_a1, g_px, g_px2} = g;
        #1;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (pm[i] && !g[i]) rdy = 1'b0;
        end
        chk("avail", {3'b0, avails}, {3'b0, pm});
        chk("pre_get", {7'b0, pre_get_x}, {7'b0, rdy});
        chk("pl_x", d_px, xm);
        chk("mult_2", d_m2, x2m);
        chk("pl_x2", d_px2, x2m);
        chk("mult_1", d_m1, CA);
        chk("add_1", d_a1, CB);
        if (!rst) begin
            pm  = '0;
            xm  = '0;
            x2m = '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (g[i]) pm[i] = 1'b0;
            end
            if (av && rdy) begin
                pm  = 5'h1F;
                xm  = x;
                x2m = ref_sq(x);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pre_avail_x = 1'b0;
        pre_data_x  = '0;
        {g_m1, g_m2, g_a1, g_px, g_px2} = '0;
        pm  = '0;
        xm  = '0;
        x2m = '0;

        @(posedge clk);
        cyc(1'b0, 1'b0, 8'h00, 5'h00);
        cyc(1'b1, 1'b0, 8'h00, 5'h00);
        chk("rst_avail", {3'b0, avails}, 8'h00);
        chk("rst_pre_get", {7'b0, pre_get_x}, 8'h01);
        chk("rst_x2", d_m2, 8'h00);

        // 1.5 squared, all gets high
        cyc(1'b1, 1'b1, 8'h18, 5'h1F);
        cyc(1'b1, 1'b0, 8'h00, 5'h1F);
        chk("x18_avail", {3'b0, avails}, 8'h1F);
        chk("x18_x2", d_m2, 8'h24);
        chk("x18_plx", d_px, 8'h18);
        chk("x18_pre_get", {7'b0, pre_get_x}, 8'h01);

        // sign and saturation corners
        cyc(1'b1, 1'b1, 8'hF0, 5'h1F);
        cyc(1'b1, 1'b1, 8'h7F, 5'h1F);
        chk("xF0_x2", d_pl_or(d_m2), 8'h10);
        cyc(1'b1, 1'b1, 8'h80, 5'h1F);
        chk("x7F_x2", d_m2, 8'h7F);
        cyc(1'b1, 1'b0, 8'h00, 5'h1F);
        chk("x80_x2", d_px2, 8'h7F);

        // staggered consumption: only pl_x takes first
        cyc(1'b1, 1'b1, 8'h18, 5'h1F);
        cyc(1'b1, 1'b1, 8'h55, 5'b00010);
        chk("stag_pre_get0", {7'b0, pre_get_x}, 8'h00);
        cyc(1'b1, 1'b1, 8'h55, 5'b00000);
        chk("stag_plx_done", {7'b0, av_px}, 8'h00);
        chk("stag_plx2_pend", {7'b0, av_px2}, 8'h01);
        chk("stag_hold_x", d_px, 8'h18);
        cyc(1'b1, 1'b1, 8'h55, 5'b11101);
        cyc(1'b1, 1'b0, 8'h00, 5'h1F);
        chk("stag_new_x", d_px, 8'h55);
        chk("stag_new_avail", {3'b0, avails}, 8'h1F);

        // back-to-back stream
        cyc(1'b1, 1'b1, 8'h10, 5'h1F);
        cyc(1'b1, 1'b1, 8'h20, 5'h1F);
        chk("b2b_10", d_m2, 8'h10);
        cyc(1'b1, 1'b1, 8'h30, 5'h1F);
        chk("b2b_20", d_m2, 8'h40);
        cyc(1'b1, 1'b0, 8'h00, 5'h1F);
        chk("b2b_30", d_m2, 8'h7F);

        // mult_2 stalled three cycles
        cyc(1'b1, 1'b1, 8'h28, 5'h1F);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 8'h33, 5'b10111);
            chk("stall_m2", d_m2, 8'h64);
            chk("stall_plx2", d_px2, 8'h64);
            chk("stall_pre_get", {7'b0, pre_get_x}, 8'h00);
        end
        cyc(1'b1, 1'b0, 8'h00, 5'h1F);

        // reset with pend = 00101
        cyc(1'b1, 1'b1, 8'h18, 5'h00);
        cyc(1'b1, 1'b0, 8'h00, 5'b11010);
        cyc(1'b0, 1'b0, 8'h00, 5'h00);
        chk("mid_pend", {3'b0, avails}, 8'h05);
        cyc(1'b0, 1'b0, 8'h00, 5'h00);
        chk("mid_rst_avail", {3'b0, avails}, 8'h00);
        chk("mid_rst_data", d_px, 8'h00);
        chk("mid_rst_pre_get", {7'b0, pre_get_x}, 8'h01);
        cyc(1'b1, 1'b0, 8'h00, 5'h00);
        chk("post_rst_pre_get", {7'b0, pre_get_x}, 8'h01);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic a;
            logic [7:0] xv;
            logic [4:0] gv;
            r  = ($urandom_range(63) != 0);
            a  = ($urandom_range(3) != 0);
            xv = 8'($urandom);
            gv = ($urandom_range(2) == 0) ? 5'h1F : 5'($urandom);
            cyc(r, a, xv, gv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [7:0] d_pl_or(input logic [7:0] v);
        return v;
    endfunction

endmodule
